bit_serial_multiplier: RTL and testbench
========================================

BIT_SERIAL_MULTIPLIER -- requirements
Module: bit_serial_multiplier

Interface
REQ-001 Parameter: K, default 7, word length in bits (serial operand and product length); K >= 2.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk.
REQ-003 Port: clk  input  1  single system clock.
REQ-004 Port: reset  input  1  asynchronous active-high reset.
REQ-005 Port: x  input  1  multiplicand serial bit, LSB first.
REQ-006 Port: y  input  1  multiplier serial bit, LSB first.
REQ-007 Port: first_bit  input  1  high in the cycle in which bit 0 of x and y is presented.
REQ-008 Port: last_bit  input  1  high while no word is in progress (idle/frame end); low for the whole word.
REQ-009 Port: p  output  1  registered product serial bit, LSB first.

Function
REQ-010 Internal state SHALL be: XS (K bits, x bits received so far), YS (K bits, y bits received so far), ACC (K+1 bits, carry accumulator), bit index i (ceil(log2 K)+1 bits), p register.
REQ-011 At each rising edge with last_bit=0, the block SHALL sample x and y as bit i of operands X and Y; first_bit=1 forces i=0 and treats XS, YS, ACC as zero for that step.
REQ-012 Per step: S = ACC + x*(YS with bit i set to y) + y*XS, using only bits 0..i of the operands, with weights relative to 2^i.
REQ-013 Per step: p register <= S[0]; ACC <= S >> 1; XS[i] <= x; YS[i] <= y; i <= i+1.
REQ-014 Latency: p after the edge that samples bit i SHALL equal bit i of X*Y, i.e. one clock of latency.
REQ-015 Product SHALL be exact modulo 2^K; bits beyond index K-1 SHALL NOT be produced.
REQ-016 Steps with i >= K (word longer than K without first_bit) SHALL drive p <= 0 and leave XS, YS and ACC unchanged.
REQ-017 An edge with last_bit=1 and first_bit=0 SHALL clear XS, YS, ACC and i, and SHALL set p <= 0.
REQ-018 first_bit=1 SHALL take priority over last_bit=1; that edge starts a new word as in REQ-011.
REQ-019 Back-to-back words: first_bit may be asserted on any edge, including the edge right after the final bit of the previous word; the new word SHALL start cleanly with no residue.
REQ-020 Operands narrower than K SHALL be zero-padded by the driver; for N-bit operands with K >= 2N+1, bits 0..2N-1 of p SHALL hold the full product.
REQ-021 The block SHALL NOT use combinational paths from inputs to p.

Reset
REQ-022 When reset is asserted, XS, YS, ACC, i and p SHALL clear to 0 immediately, independent of clk.
REQ-023 While reset is held, inputs SHALL be ignored and p SHALL remain 0.
REQ-024 After reset release, the block SHALL be idle and SHALL wait for first_bit; a word interrupted by reset SHALL be discarded.

Verification
REQ-025 K=7, X=3, Y=3 driven over 6 cycles with first_bit on cycle 0 -> p sequence 1,0,0,1,0,0 (9).
REQ-026 X=5, Y=7 -> p bits assemble to 35; X=7, Y=7 -> 49; X=0, Y=6 -> 0.
REQ-027 Exhaustive check: all 64 pairs 0..7 x 0..7, each word of 6 bit-cycles followed by 3 cycles with last_bit=1 -> every assembled result equals a*b; the test passes only if all 64 pass.
REQ-028 Back-to-back words (5x5 then 3x3) with first_bit on the edge immediately after the previous word's last bit -> results 25 then 9 with no carry leakage.
REQ-029 Reset asserted mid-word (after bit 2 of 7x7) -> p goes to 0 at once; a following 2x3 word -> 6.

Source files
------------

// File: rtl/bit_serial_multiplier.sv
// LSB-first bit-serial multiplier: one product bit per clock, exact modulo 2^K.
// A word starts on first_bit; last_bit without first_bit idles and clears the datapath.
module bit_serial_multiplier #(
    parameter int unsigned K = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    input  logic y,
    input  logic first_bit,
    input  logic last_bit,
    output logic p
);

    localparam int unsigned IW = $clog2(K) + 1;
    localparam int unsigned SW = K + 2;

    logic [K-1:0]  xs;
    logic [K-1:0]  ys;
    logic [K:0]    acc;
    logic [IW-1:0] idx;

    logic [IW-1:0] idx_c;
    logic [K-1:0]  xs_c;
    logic [K-1:0]  ys_c;
    logic [K:0]    acc_c;
    logic [K-1:0]  mask_c;
    logic [K-1:0]  xbit_c;
    logic [K-1:0]  ybit_c;
    logic [K-1:0]  xterm_c;
    logic [K-1:0]  yterm_c;
    logic [SW-1:0] sum_c;
    logic          active_c;

    // One step of the serial partial-product sum, weights relative to 2^idx
    always_comb begin
        idx_c    = first_bit ? '0 : idx;
        xs_c     = first_bit ? '0 : xs;
        ys_c     = first_bit ? '0 : ys;
        acc_c    = first_bit ? '0 : acc;
        active_c = (idx_c < IW'(K));
        mask_c   = (K'(1) << idx_c) - K'(1);
        xbit_c   = K'(x) << idx_c;
        ybit_c   = K'(y) << idx_c;
        xterm_c  = x ? ((ys_c & mask_c) | ybit_c) : '0;
        yterm_c  = y ? (xs_c & mask_c) : '0;
        sum_c    = SW'(acc_c) + SW'(xterm_c) + SW'(yterm_c);
    end

    // Datapath state; bit steps past K-1 emit zeros and hold the operands
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xs  <= '0;
            ys  <= '0;
            acc <= '0;
            idx <= '0;
            p   <= 1'b0;
        end else if (first_bit || !last_bit) begin
            if (active_c) begin
                p   <= sum_c[0];
                acc <= sum_c[SW-1:1];
                xs  <= xs_c | xbit_c;
                ys  <= ys_c | ybit_c;
                idx <= idx_c + IW'(1);
            end else begin
                p <= 1'b0;
            end
        end else begin
            xs  <= '0;
            ys  <= '0;
            acc <= '0;
            idx <= '0;
            p   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_serial_multiplier.sv
// Self-checking bench for bit_serial_multiplier; reference is plain integer a*b mod 2^K.
module tb_bit_serial_multiplier;

    localparam int unsigned K = 7;

    logic clk;
    logic reset;
    logic x;
    logic y;
    logic first_bit;
    logic last_bit;
    logic p;

    int n_checks;
    int n_fail;

    bit_serial_multiplier #(.K(K)) dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .first_bit (first_bit),
        .last_bit  (last_bit),
        .p         (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive inputs at the falling edge, return 1 time unit after the sampling edge
    task automatic drive_step(input logic xb, input logic yb, input logic fb, input logic lb);
        @(negedge clk);
        x         = xb;
        y         = yb;
        first_bit = fb;
        last_bit  = lb;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_step(1'($urandom), 1'($urandom), 1'b0, 1'b1);
            check("idle_p", longint'(p), 0);
        end
    endtask

    // Serial word: checks each product bit and returns the assembled value
    task automatic run_word(input string tag, input longint a, input longint b,
                            input int nbits, input bit lb_on_first, output longint got);
        longint prod;
        longint eb;
        prod = (a * b) % (longint'(1) << K);
        got  = 0;
        for (int i = 0; i < nbits; i++) begin
            drive_step(1'((a >> i) & 1), 1'((b >> i) & 1), (i == 0),
                       (i == 0) ? lb_on_first : 1'b0);
            eb = (i < int'(K)) ? ((prod >> i) & 1) : 0;
            check({tag, "_bit"}, longint'(p), eb);
            if (p === 1'b1 && i < 62) got = got | (longint'(1) << i);
        end
    endtask

    initial begin
        longint got;
        longint a;
        longint b;
        int     good;

        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        x         = 1'b0;
        y         = 1'b0;
        first_bit = 1'b0;
        last_bit  = 1'b1;

        #2 reset = 1'b1;
        #1 check("reset_async", longint'(p), 0);
        // Inputs ignored while reset is held
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            x = 1'b1; y = 1'b1; first_bit = 1'b1; last_bit = 1'b0;
            @(posedge clk);
            #1 check("reset_hold", longint'(p), 0);
        end
        @(negedge clk);
        reset = 1'b0;
        first_bit = 1'b0; last_bit = 1'b1;
        idle(2);

        run_word("w3x3", 3, 3, 6, 1'b0, got);
        check("w3x3", got, 9);
        idle(3);
        run_word("w5x7", 5, 7, 6, 1'b0, got);
        check("w5x7", got, 35);
        idle(3);
        run_word("w7x7", 7, 7, 6, 1'b0, got);
        check("w7x7", got, 49);
        idle(3);
        run_word("w0x6", 0, 6, 6, 1'b0, got);
        check("w0x6", got, 0);
        idle(3);

        good = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                run_word("exh", i, j, 6, 1'b0, got);
                if (got == longint'(i * j)) good++;
                idle(3);
            end
        end
        check("exhaustive_all", longint'(good), 64);

        // Back-to-back words: first_bit on the edge right after the last bit
        run_word("b2b_5x5", 5, 5, 6, 1'b0, got);
        check("b2b_5x5", got, 25);
        run_word("b2b_3x3", 3, 3, 6, 1'b0, got);
        check("b2b_3x3", got, 9);

        // first_bit wins over last_bit
        run_word("prio_6x5", 6, 5, 6, 1'b1, got);
        check("prio_6x5", got, 30);
        idle(1);

        // Random full-width and overlong words; bits beyond K-1 must be zero
        for (int n = 0; n < 20; n++) begin
            a = longint'($urandom_range(0, (1 << K) - 1));
            b = longint'($urandom_range(0, (1 << K) - 1));
            run_word("rnd", a, b, (n % 2 == 0) ? int'(K) : int'(K) + 3, 1'b0, got);
            check("rnd_word", got, (a * b) % (longint'(1) << K));
            if (n % 3 == 0) idle(1);
        end
        idle(2);

        // Reset mid-word while p is high, cleared before the next clock edge
        drive_step(1'b1, 1'b1, 1'b1, 1'b0);
        drive_step(1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_reset_p", longint'(p), 1);
        #2 reset = 1'b1;
        #1 check("reset_midword", longint'(p), 0);
        @(negedge clk);
        reset = 1'b0;
        idle(1);

        // Reset after bit 2 of 7x7, then a clean 2x3 word
        drive_step(1'b1, 1'b1, 1'b1, 1'b0);
        drive_step(1'b1, 1'b1, 1'b0, 1'b0);
        drive_step(1'b1, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1 check("reset_7x7", longint'(p), 0);
        @(posedge clk);
        #1 check("reset_7x7_hold", longint'(p), 0);
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        run_word("post_rst_2x3", 2, 3, 6, 1'b0, got);
        check("post_rst_2x3", got, 6);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
